// File: rtl/rv64wb_arbiter_pkg.sv
// ============================================================================
// Module      : rv64wb_arbiter_pkg
// Description : Shared sizes and writeback requester IDs for rv64wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv64wb_arbiter_pkg;

    localparam int XLEN          = 64;
    localparam int REG_ADDRWIDTH = 5;
    localparam int REG_NUM       = 32;

    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_req_e;

    function automatic wb_req_e wb_other(input wb_req_e req);
        return (req == WB_EXU) ? WB_LSU : WB_EXU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv64wb_arbiter_if.sv
// ============================================================================
// Module      : rv64wb_arbiter_if
// Description : Writeback, issue, hazard-query and register-file write bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv64wb_arbiter_if
    import rv64wb_arbiter_pkg::*;
#(
    parameter int XLEN          = rv64wb_arbiter_pkg::XLEN,
    parameter int REG_ADDRWIDTH = rv64wb_arbiter_pkg::REG_ADDRWIDTH,
    parameter int REG_NUM       = rv64wb_arbiter_pkg::REG_NUM
) ();

    logic                       exu_wb_valid;
    logic                       exu_wb_ready;
    logic [REG_ADDRWIDTH-1:0]   exu_wb_idx;
    logic [XLEN-1:0]            exu_wb_data;

    logic                       lsu_wb_valid;
    logic                       lsu_wb_ready;
    logic [REG_ADDRWIDTH-1:0]   lsu_wb_idx;
    logic [XLEN-1:0]            lsu_wb_data;

    logic                       issue_valid;
    logic [REG_ADDRWIDTH-1:0]   issue_rd;
    logic                       issue_ready;

    logic [REG_ADDRWIDTH-1:0]   rs1_idx;
    logic [REG_ADDRWIDTH-1:0]   rs2_idx;
    logic                       rs1_busy;
    logic                       rs2_busy;

    logic [REG_ADDRWIDTH-1:0]   write_idx;
    logic [XLEN-1:0]            write_data;
    logic                       wen;
    logic [$clog2(REG_NUM):0]   pending_cnt;

    modport master (
        output exu_wb_valid, exu_wb_idx, exu_wb_data,
        input  exu_wb_ready,
        output lsu_wb_valid, lsu_wb_idx, lsu_wb_data,
        input  lsu_wb_ready,
        output issue_valid, issue_rd,
        input  issue_ready,
        output rs1_idx, rs2_idx,
        input  rs1_busy, rs2_busy,
        input  write_idx, write_data, wen, pending_cnt
    );

    modport slave (
        input  exu_wb_valid, exu_wb_idx, exu_wb_data,
        output exu_wb_ready,
        input  lsu_wb_valid, lsu_wb_idx, lsu_wb_data,
        output lsu_wb_ready,
        input  issue_valid, issue_rd,
        output issue_ready,
        input  rs1_idx, rs2_idx,
        output rs1_busy, rs2_busy,
        output write_idx, write_data, wen, pending_cnt
    );

endinterface

`default_nettype wire

// File: rtl/rv64wb_arbiter_scoreboard.sv
// ============================================================================
// Module      : rv64scoreboard
// Description : Per-register busy vector with issue stall, hazard queries and
//               a count of registers awaiting writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv64scoreboard
    import rv64wb_arbiter_pkg::*;
#(
    parameter int REG_ADDRWIDTH = rv64wb_arbiter_pkg::REG_ADDRWIDTH,
    parameter int REG_NUM       = rv64wb_arbiter_pkg::REG_NUM,
    localparam int CNT_W        = $clog2(REG_NUM) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [REG_ADDRWIDTH-1:0] issue_rd,
    output logic                     issue_ready,
    input  logic                     clr_valid,
    input  logic [REG_ADDRWIDTH-1:0] clr_idx,
    input  logic [REG_ADDRWIDTH-1:0] rs1_idx,
    input  logic [REG_ADDRWIDTH-1:0] rs2_idx,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [CNT_W-1:0]         pending_cnt
);

    logic [REG_NUM-1:0] busy;
    logic               set_en;
    logic               clr_en;

    assign issue_ready = !issue_valid || (issue_rd == '0) || !busy[issue_rd];
    assign set_en      = issue_valid && issue_ready && (issue_rd != '0);
    // Only a genuinely busy bit decrements the count; CSR-style writes to idle registers do not.
    assign clr_en      = clr_valid && busy[clr_idx];

    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_idx] <= 1'b0;
            end
            if (set_en) begin
                busy[issue_rd] <= 1'b1;
            end
            busy[0] <= 1'b0;
            case ({set_en, clr_en})
                2'b10:   pending_cnt <= pending_cnt + CNT_W'(1);
                2'b01:   pending_cnt <= pending_cnt - CNT_W'(1);
                default: pending_cnt <= pending_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv64wb_arbiter.sv
// ============================================================================
// Module      : rv64wb_arbiter
// Description : Round-robin EXU/LSU writeback arbiter with a registered
//               register-file write stage and a busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv64wb_arbiter
    import rv64wb_arbiter_pkg::*;
#(
    parameter int XLEN          = rv64wb_arbiter_pkg::XLEN,
    parameter int REG_ADDRWIDTH = rv64wb_arbiter_pkg::REG_ADDRWIDTH,
    parameter int REG_NUM       = rv64wb_arbiter_pkg::REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    rv64wb_arbiter_if.slave   bus
);

    wb_req_e                  rr_ptr;
    wb_req_e                  grant;
    logic                     fire;
    logic [REG_ADDRWIDTH-1:0] sel_idx;
    logic [XLEN-1:0]          sel_data;

    // Idle and contended cycles both follow the pointer, so ready never waits on valid.
    always_comb begin
        grant = rr_ptr;
        if (bus.exu_wb_valid && !bus.lsu_wb_valid) begin
            grant = WB_EXU;
        end else if (!bus.exu_wb_valid && bus.lsu_wb_valid) begin
            grant = WB_LSU;
        end
    end

    assign bus.exu_wb_ready = (grant == WB_EXU);
    assign bus.lsu_wb_ready = (grant == WB_LSU);

    always_comb begin
        fire     = 1'b0;
        sel_idx  = bus.exu_wb_idx;
        sel_data = bus.exu_wb_data;
        if (grant == WB_EXU) begin
            fire = bus.exu_wb_valid;
        end else begin
            fire     = bus.lsu_wb_valid;
            sel_idx  = bus.lsu_wb_idx;
            sel_data = bus.lsu_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= WB_EXU;
            bus.wen        <= 1'b0;
            bus.write_idx  <= '0;
            bus.write_data <= '0;
        end else if (fire) begin
            rr_ptr         <= wb_other(grant);
            bus.wen        <= (sel_idx != '0);
            bus.write_idx  <= sel_idx;
            bus.write_data <= sel_data;
        end else begin
            bus.wen        <= 1'b0;
        end
    end

    rv64scoreboard #(
        .REG_ADDRWIDTH (REG_ADDRWIDTH),
        .REG_NUM       (REG_NUM)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .issue_ready (bus.issue_ready),
        .clr_valid   (bus.wen),
        .clr_idx     (bus.write_idx),
        .rs1_idx     (bus.rs1_idx),
        .rs2_idx     (bus.rs2_idx),
        .rs1_busy    (bus.rs1_busy),
        .rs2_busy    (bus.rs2_busy),
        .pending_cnt (bus.pending_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_rv64wb_arbiter.sv
// ============================================================================
// Module      : tb_rv64wb_arbiter
// Description : Directed vector table for rv64wb_arbiter plus a mid-write reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv64wb_arbiter;

    logic clk;
    logic rst;

    rv64wb_arbiter_if #(.XLEN(64), .REG_ADDRWIDTH(5), .REG_NUM(32)) bus ();

    rv64wb_arbiter #(.XLEN(64), .REG_ADDRWIDTH(5), .REG_NUM(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ev;  logic [4:0] eidx; logic [63:0] edata;
        logic        lv;  logic [4:0] lidx; logic [63:0] ldata;
        logic        iv;  logic [4:0] ird;
        logic [4:0]  rs1; logic [4:0] rs2;
        logic        er;  logic lr; logic ir; logic b1; logic b2; logic wen;
        logic [4:0]  widx; logic [63:0] wdata; logic [5:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    function automatic vec_t mk(
        input logic r,
        input logic ev, input logic [4:0] eidx, input logic [63:0] edata,
        input logic lv, input logic [4:0] lidx, input logic [63:0] ldata,
        input logic iv, input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic er, input logic lr, input logic ir, input logic b1, input logic b2,
        input logic wen, input logic [4:0] widx, input logic [63:0] wdata, input logic [5:0] cnt);
        vec_t v;
        v.rst = r;   v.ev = ev; v.eidx = eidx; v.edata = edata;
        v.lv = lv;   v.lidx = lidx; v.ldata = ldata;
        v.iv = iv;   v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.er = er;   v.lr = lr; v.ir = ir; v.b1 = b1; v.b2 = b2;
        v.wen = wen; v.widx = widx; v.wdata = wdata; v.cnt = cnt;
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge, compare all outputs mid-cycle.
    task automatic apply(input vec_t v, input string name);
        logic [80:0] got;
        logic [80:0] want;
        @(posedge clk);
        #1;
        rst              = v.rst;
        bus.exu_wb_valid = v.ev; bus.exu_wb_idx = v.eidx; bus.exu_wb_data = v.edata;
        bus.lsu_wb_valid = v.lv; bus.lsu_wb_idx = v.lidx; bus.lsu_wb_data = v.ldata;
        bus.issue_valid  = v.iv; bus.issue_rd   = v.ird;
        bus.rs1_idx      = v.rs1; bus.rs2_idx   = v.rs2;
        @(negedge clk);
        got  = {bus.exu_wb_ready, bus.lsu_wb_ready, bus.issue_ready, bus.rs1_busy,
                bus.rs2_busy, bus.wen, bus.write_idx, bus.write_data, bus.pending_cnt};
        want = {v.er, v.lr, v.ir, v.b1, v.b2, v.wen, v.widx, v.wdata, v.cnt};
        vectors_applied++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got er=%b lr=%b ir=%b b1=%b b2=%b wen=%b widx=%0d wdata=%h cnt=%0d, expected er=%b lr=%b ir=%b b1=%b b2=%b wen=%b widx=%0d wdata=%h cnt=%0d",
                     name, bus.exu_wb_ready, bus.lsu_wb_ready, bus.issue_ready, bus.rs1_busy,
                     bus.rs2_busy, bus.wen, bus.write_idx, bus.write_data, bus.pending_cnt,
                     v.er, v.lr, v.ir, v.b1, v.b2, v.wen, v.widx, v.wdata, v.cnt);
        end
    endtask

    property p_hold(logic valid, logic ready, logic [4:0] idx, logic [63:0] data);
        @(posedge clk) disable iff (rst)
            (valid && !ready) |=> (valid && $stable(idx) && $stable(data));
    endproperty

    a_exu_hold: assert property (p_hold(bus.exu_wb_valid, bus.exu_wb_ready, bus.exu_wb_idx, bus.exu_wb_data));
    a_lsu_hold: assert property (p_hold(bus.lsu_wb_valid, bus.lsu_wb_ready, bus.lsu_wb_idx, bus.lsu_wb_data));

    initial begin
        //            rst ev eidx edata   lv lidx ldata   iv ird rs1 rs2   er lr ir b1 b2 wen widx wdata     cnt
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  0, 0,    1, 0, 1, 0, 0, 0, 0, 64'h0,    0)); // idle after reset
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 5,  5, 0,    1, 0, 1, 0, 0, 0, 0, 64'h0,    0)); // issue x5
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  5, 0,    1, 0, 1, 1, 0, 0, 0, 64'h0,    1));
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  5, 0,    1, 0, 1, 1, 0, 0, 0, 64'h0,    1));
        vecs.push_back(mk(0, 1, 5, 64'hDEAD, 0, 0, 64'h0,  0, 0,  5, 0,    1, 0, 1, 1, 0, 0, 0, 64'h0,    1)); // EXU wb x5
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  5, 0,    0, 1, 1, 1, 0, 1, 5, 64'hDEAD, 1)); // wen cycle, still busy
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  5, 0,    0, 1, 1, 0, 0, 0, 5, 64'hDEAD, 0));
        vecs.push_back(mk(0, 0, 0, 64'h0,    1, 0, 64'hFF, 0, 0,  0, 0,    0, 1, 1, 0, 0, 0, 5, 64'hDEAD, 0)); // LSU wb x0
        vecs.push_back(mk(0, 1, 1, 64'h11,   1, 2, 64'h22, 0, 0,  0, 0,    1, 0, 1, 0, 0, 0, 0, 64'hFF,   0)); // contention
        vecs.push_back(mk(0, 1, 1, 64'h11,   1, 2, 64'h22, 0, 0,  0, 0,    0, 1, 1, 0, 0, 1, 1, 64'h11,   0));
        vecs.push_back(mk(0, 1, 1, 64'h11,   1, 2, 64'h22, 0, 0,  0, 0,    1, 0, 1, 0, 0, 1, 2, 64'h22,   0));
        vecs.push_back(mk(0, 1, 1, 64'h11,   1, 2, 64'h22, 0, 0,  0, 0,    0, 1, 1, 0, 0, 1, 1, 64'h11,   0));
        vecs.push_back(mk(0, 1, 1, 64'h11,   0, 0, 64'h0,  0, 0,  0, 0,    1, 0, 1, 0, 0, 1, 2, 64'h22,   0));
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  0, 0,    0, 1, 1, 0, 0, 1, 1, 64'h11,   0));
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 7,  0, 0,    0, 1, 1, 0, 0, 0, 1, 64'h11,   0)); // issue x7
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 7,  0, 7,    0, 1, 0, 0, 1, 0, 1, 64'h11,   1)); // WAW stall
        vecs.push_back(mk(0, 1, 7, 64'h77,   0, 0, 64'h0,  1, 7,  0, 7,    1, 0, 0, 0, 1, 0, 1, 64'h11,   1));
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 7,  0, 7,    0, 1, 0, 0, 1, 1, 7, 64'h77,   1));
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 7,  0, 7,    0, 1, 1, 0, 0, 0, 7, 64'h77,   0)); // re-issue accepted
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 0,  0, 7,    0, 1, 1, 0, 1, 0, 7, 64'h77,   1)); // issue x0
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  0, 7,    0, 1, 1, 0, 1, 0, 7, 64'h77,   1));
        vecs.push_back(mk(0, 1, 7, 64'h1,    0, 0, 64'h0,  0, 0,  0, 0,    1, 0, 1, 0, 0, 0, 7, 64'h77,   1));
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 3,  0, 0,    0, 1, 1, 0, 0, 1, 7, 64'h1,    1)); // set x3, clear x7
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  3, 7,    0, 1, 1, 1, 0, 0, 7, 64'h1,    1));
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 9,  0, 0,    0, 1, 1, 0, 0, 0, 7, 64'h1,    1));
        vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 64'h0,  1, 10, 0, 0,    0, 1, 1, 0, 0, 0, 7, 64'h1,    2));

        rst = 1'b1;
        bus.exu_wb_valid = 1'b0; bus.exu_wb_idx = '0; bus.exu_wb_data = '0;
        bus.lsu_wb_valid = 1'b0; bus.lsu_wb_idx = '0; bus.lsu_wb_data = '0;
        bus.issue_valid  = 1'b0; bus.issue_rd   = '0;
        bus.rs1_idx      = '0;   bus.rs2_idx    = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a write is in flight and x3, x9, x10 are busy; pointer sits at LSU.
        apply(mk(0, 1, 3, 64'h33, 0, 0, 64'h0, 0, 0, 9, 10,  1, 0, 1, 1, 1, 0, 7, 64'h1,  3), "rst_pre_fire");
        apply(mk(1, 0, 0, 64'h0,  0, 0, 64'h0, 0, 0, 9, 10,  0, 1, 1, 1, 1, 1, 3, 64'h33, 3), "rst_during_wen");
        apply(mk(0, 0, 0, 64'h0,  0, 0, 64'h0, 0, 0, 9, 10,  1, 0, 1, 0, 0, 0, 0, 64'h0,  0), "rst_after");
        apply(mk(0, 0, 0, 64'h0,  0, 0, 64'h0, 1, 3, 3, 0,   1, 0, 1, 0, 0, 0, 0, 64'h0,  0), "rst_x3_free");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv64wb_arbiter.md
# rv64wb_arbiter

Writeback controller for the single-write-port RV64 integer register file. Shares the file's one write port between two writeback requesters, the execute unit (EXU) and the load/store unit (LSU), using round-robin arbitration and a registered output stage. Also keeps a per-register busy scoreboard so the decode stage can stall on RAW and WAW hazards. Sits between EXU/LSU writeback and the register file write port; the register file's read ports are not touched.

## Interface
- XLEN, default `XLEN (64): data width.
- REG_ADDRWIDTH, default `REG_ADDRWIDTH (5): register index width.
- REG_NUM, default `REG_NUM (32): number of architectural registers.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- exu_wb_valid / exu_wb_ready  in / out  1  EXU writeback handshake.
- exu_wb_idx  in  REG_ADDRWIDTH  EXU destination register.
- exu_wb_data  in  XLEN  EXU result.
- lsu_wb_valid / lsu_wb_ready  in / out  1  LSU writeback handshake.
- lsu_wb_idx  in  REG_ADDRWIDTH  LSU destination register.
- lsu_wb_data  in  XLEN  LSU load data.
- issue_valid  in  1  decode requests to mark a destination register busy.
- issue_rd  in  REG_ADDRWIDTH  destination register being issued.
- issue_ready  out  1  issue is accepted this cycle.
- rs1_idx, rs2_idx  in  REG_ADDRWIDTH  hazard query indices.
- rs1_busy, rs2_busy  out  1  the queried register has a pending write (combinational).
- write_idx  out  REG_ADDRWIDTH  to the register file write port.
- write_data  out  XLEN  to the register file write port.
- wen  out  1  to the register file write port.
- pending_cnt  out  $clog2(REG_NUM)+1  number of busy registers.

## Operation
- Arbitration
  - A requester's transfer fires when valid && ready.
  - The output stage always drains in one cycle, so exactly the granted requester sees ready=1 every cycle. Ready does not depend on the requester's own valid, except as stated below.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last time is granted. The round-robin pointer updates only on a fired transfer.
  - Neither valid: ready follows the pointer (points at the non-last winner); pointer unchanged.
- Output stage
  - A fired transfer registers idx and data.
  - wen is asserted the next cycle unless idx==0. A write to x0 is accepted but wen stays 0.
  - write_idx and write_data update on every fired transfer. They hold their value otherwise.
- Scoreboard
  - busy[REG_NUM] bit vector; busy[0] is hard-wired to 0.
  - issue_ready = !issue_valid || issue_rd==0 || !busy[issue_rd]. An issue to a busy register stalls, which prevents WAW.
  - An accepted issue with rd≠0 sets busy[rd].
  - busy[write_idx] is cleared on the posedge that ends a wen cycle, which is the same edge the register file captures the data.
  - A writeback to a non-busy register (for example a CSR result) performs the write; clearing the bit is a no-op.
  - Set and clear of the same index in one cycle cannot occur: the register is still busy, so the issue stalls.
  - Set and clear of different indices in the same cycle both take effect.
  - rs1_busy and rs2_busy read busy directly. There is no bypass: a register still reads busy during its own wen cycle.
- pending_cnt
  - +1 on an accepted issue with rd≠0.
  - −1 on a wen clear of a busy bit.
  - Both in the same cycle: net 0.
- Reset values: wen=0, write_idx=0, write_data=0, all busy=0, pending_cnt=0, round-robin pointer=EXU. A reset mid-operation discards the pending output-stage write.

## Timing
- Latency: transfer fires in cycle N → wen=1 in cycle N+1 → register file updated and busy cleared at the end of N+1. Issue in cycle N → busy visible in N+1.
- Throughput: one writeback per cycle total. A continuously valid pair alternates EXU, LSU, EXU, and so on.
- Handshake rules for requesters:
  - Hold valid, idx and data stable until ready.
  - Deasserting valid before ready is illegal.
  - The bench asserts these as properties.

## Structure
- Shared definitions come from sysconfig.v: `XLEN, `REG_ADDRWIDTH, `REG_NUM.
- Requester IDs (WB_EXU=0, WB_LSU=1) go in the same shared header.
- Sub-module rv64scoreboard holds the busy vector, issue_ready, the query ports and pending_cnt. The arbiter and output stage stay in rv64wb_arbiter.

## Test plan
- Reset, then idle: wen=0, pending_cnt=0, rs1_busy=rs2_busy=0, exu_wb_ready=1.
- Issue rd=5 in cycle 1, query rs1_idx=5 → busy=1 from cycle 2. EXU writeback idx=5, data=0xDEAD in cycle 4 → wen=1, write_idx=5 in cycle 5; busy=0 and pending_cnt=0 in cycle 6.
- EXU and LSU both valid for 4 cycles (idx 1 vs 2) → grants EXU, LSU, EXU, LSU; wen sequence 1,2,1,2.
- Issue rd=7 twice back-to-back → second issue_ready=0 until the writeback to 7 completes, then accepted; pending_cnt never exceeds 1.
- Writeback to x0 with data 0xFF → ready=1, wen stays 0. Issue rd=0 → issue_ready=1, pending_cnt unchanged.
- Assert rst while wen=1 and three registers are busy → next cycle wen=0, all busy=0, pending_cnt=0, pointer=EXU.
